// File: rtl/hsv_core_commit.sv
// hsv_core_commit: in-order commit/writeback stage.
//
// Accepts one result record per cycle from the ALU, branch, control-status
// and memory units, strictly in sequence-tag order, and drives the
// register-file write port. A trap record, or a taken branch, starts a
// pipeline flush with a PC redirect. Commit stalls in FLUSH until
// flush_ack is seen.
//
// Ports:
//   clk_core, rst_core_n          clock, asynchronous active-low reset
//   <u>_valid_i/<u>_ready_o       per-unit handshake (alu, branch,
//                                 ctrl_status, mem)
//   <u>_tag/_rd/_wb/_result/_trap per-unit result record
//   branch_redirect/branch_target taken-branch control for branch records
//   wr_addr/wr_data/wr_en         register-file write port (1-cycle latency)
//   flush_req/flush_ack           upstream flush handshake
//   redirect_valid_o/redirect_pc_o  one-cycle PC redirect strobe + held target
//   retired_count                 retired-instruction counter
//
// Build option: HSV_COMMIT_RETIRE_CNT_EN enables the retired-instruction
// counter; without it retired_count is tied to 0.

module hsv_core_commit #(
  parameter int unsigned TAG_W       = 4,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic             clk_core,
  input  logic             rst_core_n,

  input  logic             alu_valid_i,
  output logic             alu_ready_o,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [4:0]       alu_rd,
  input  logic             alu_wb,
  input  logic [31:0]      alu_result,
  input  logic             alu_trap,

  input  logic             branch_valid_i,
  output logic             branch_ready_o,
  input  logic [TAG_W-1:0] branch_tag,
  input  logic [4:0]       branch_rd,
  input  logic             branch_wb,
  input  logic [31:0]      branch_result,
  input  logic             branch_trap,
  input  logic             branch_redirect,
  input  logic [31:0]      branch_target,

  input  logic             ctrl_status_valid_i,
  output logic             ctrl_status_ready_o,
  input  logic [TAG_W-1:0] ctrl_status_tag,
  input  logic [4:0]       ctrl_status_rd,
  input  logic             ctrl_status_wb,
  input  logic [31:0]      ctrl_status_result,
  input  logic             ctrl_status_trap,

  input  logic             mem_valid_i,
  output logic             mem_ready_o,
  input  logic [TAG_W-1:0] mem_tag,
  input  logic [4:0]       mem_rd,
  input  logic             mem_wb,
  input  logic [31:0]      mem_result,
  input  logic             mem_trap,

  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic             wr_en,

  output logic             flush_req,
  input  logic             flush_ack,

  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,

  output logic [63:0]      retired_count
);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [TAG_W-1:0] expected_tag_q, expected_tag_d;

  logic alu_match, branch_match, ctrl_status_match, mem_match;

  // Selected (winning) record
  logic        hs;
  logic [4:0]  sel_rd;
  logic        sel_wb;
  logic [31:0] sel_result;
  logic        sel_trap;
  logic        sel_redirect;

  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  assign alu_match         = alu_valid_i         && (alu_tag         == expected_tag_q);
  assign branch_match      = branch_valid_i      && (branch_tag      == expected_tag_q);
  assign ctrl_status_match = ctrl_status_valid_i && (ctrl_status_tag == expected_tag_q);
  assign mem_match         = mem_valid_i         && (mem_tag         == expected_tag_q);

  // State register
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q        <= ST_RUN;
      expected_tag_q <= '0;
    end else begin
      state_q        <= state_d;
      expected_tag_q <= expected_tag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    expected_tag_d = expected_tag_q;
    case (state_q)
      ST_RUN: begin
        if (hs) begin
          expected_tag_d = expected_tag_q + 1'b1;
          if (sel_trap || sel_redirect) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Upstream restarts tag allocation at 0 once the flush completes.
        if (flush_ack) begin
          state_d        = ST_RUN;
          expected_tag_d = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic: only the highest-priority matching unit sees ready, so at
  // most one record is accepted per cycle even on a duplicate-tag error.
  always_comb begin
    alu_ready_o         = 1'b0;
    branch_ready_o      = 1'b0;
    ctrl_status_ready_o = 1'b0;
    mem_ready_o         = 1'b0;
    flush_req           = 1'b0;
    case (state_q)
      ST_RUN: begin
        alu_ready_o         = alu_match;
        branch_ready_o      = branch_match && !alu_match;
        ctrl_status_ready_o = ctrl_status_match && !alu_match && !branch_match;
        mem_ready_o         = mem_match && !alu_match && !branch_match &&
                              !ctrl_status_match;
      end
      ST_FLUSH: flush_req = 1'b1;
      default: ;
    endcase
  end

  // Record select
  always_comb begin
    hs           = 1'b0;
    sel_rd       = '0;
    sel_wb       = 1'b0;
    sel_result   = '0;
    sel_trap     = 1'b0;
    sel_redirect = 1'b0;
    if (alu_ready_o) begin
      hs         = 1'b1;
      sel_rd     = alu_rd;
      sel_wb     = alu_wb;
      sel_result = alu_result;
      sel_trap   = alu_trap;
    end else if (branch_ready_o) begin
      hs           = 1'b1;
      sel_rd       = branch_rd;
      sel_wb       = branch_wb;
      sel_result   = branch_result;
      sel_trap     = branch_trap;
      sel_redirect = branch_redirect;
    end else if (ctrl_status_ready_o) begin
      hs         = 1'b1;
      sel_rd     = ctrl_status_rd;
      sel_wb     = ctrl_status_wb;
      sel_result = ctrl_status_result;
      sel_trap   = ctrl_status_trap;
    end else if (mem_ready_o) begin
      hs         = 1'b1;
      sel_rd     = mem_rd;
      sel_wb     = mem_wb;
      sel_result = mem_result;
      sel_trap   = mem_trap;
    end
  end

  // Writeback and redirect datapath
  always_comb begin
    wr_en_d          = hs && sel_wb && !sel_trap && (sel_rd != 5'd0);
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    redirect_valid_d = hs && (sel_trap || sel_redirect);
    redirect_pc_d    = redirect_pc_q;
    if (wr_en_d) begin
      wr_addr_d = sel_rd;
      wr_data_d = sel_result;
    end
    // A trap wins over a branch redirect on the same record.
    if (redirect_valid_d) begin
      redirect_pc_d = sel_trap ? TRAP_VECTOR : branch_target;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

`ifdef HSV_COMMIT_RETIRE_CNT_EN
  logic [63:0] retired_count_q, retired_count_d;

  always_comb begin
    retired_count_d = hs ? retired_count_q + 64'd1 : retired_count_q;
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) retired_count_q <= '0;
    else             retired_count_q <= retired_count_d;
  end

  assign retired_count = retired_count_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_hsv_core_commit.sv
// Self-checking bench for hsv_core_commit (default parameters, TAG_W=4).
// Expected register writes and redirects are pushed to scoreboards when the
// stimulus is driven and popped by monitors when the DUT produces them.

module tb_hsv_core_commit;

  localparam int UALU = 0, UBR = 1, UCS = 2, UMEM = 3;

  logic        clk_core = 1'b0;
  logic        rst_core_n;

  logic        alu_valid_i, alu_ready_o, alu_wb, alu_trap;
  logic [3:0]  alu_tag;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;

  logic        branch_valid_i, branch_ready_o, branch_wb, branch_trap, branch_redirect;
  logic [3:0]  branch_tag;
  logic [4:0]  branch_rd;
  logic [31:0] branch_result, branch_target;

  logic        ctrl_status_valid_i, ctrl_status_ready_o, ctrl_status_wb, ctrl_status_trap;
  logic [3:0]  ctrl_status_tag;
  logic [4:0]  ctrl_status_rd;
  logic [31:0] ctrl_status_result;

  logic        mem_valid_i, mem_ready_o, mem_wb, mem_trap;
  logic [3:0]  mem_tag;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;

  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        flush_req, flush_ack;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [63:0] retired_count;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [36:0] wq[$];
  logic [31:0] rq[$];

  always #5 clk_core = ~clk_core;

  hsv_core_commit #(.TAG_W(4), .TRAP_VECTOR(32'h0000_0100)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_tag(alu_tag),
    .alu_rd(alu_rd), .alu_wb(alu_wb), .alu_result(alu_result), .alu_trap(alu_trap),
    .branch_valid_i(branch_valid_i), .branch_ready_o(branch_ready_o),
    .branch_tag(branch_tag), .branch_rd(branch_rd), .branch_wb(branch_wb),
    .branch_result(branch_result), .branch_trap(branch_trap),
    .branch_redirect(branch_redirect), .branch_target(branch_target),
    .ctrl_status_valid_i(ctrl_status_valid_i), .ctrl_status_ready_o(ctrl_status_ready_o),
    .ctrl_status_tag(ctrl_status_tag), .ctrl_status_rd(ctrl_status_rd),
    .ctrl_status_wb(ctrl_status_wb), .ctrl_status_result(ctrl_status_result),
    .ctrl_status_trap(ctrl_status_trap),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_tag(mem_tag),
    .mem_rd(mem_rd), .mem_wb(mem_wb), .mem_result(mem_result), .mem_trap(mem_trap),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .retired_count(retired_count)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic rdy(input int u);
    case (u)
      UALU:    return alu_ready_o;
      UBR:     return branch_ready_o;
      UCS:     return ctrl_status_ready_o;
      default: return mem_ready_o;
    endcase
  endfunction

  task automatic drive(input int u, input logic [3:0] tag, input logic [4:0] rd,
                       input logic wb, input logic [31:0] res, input logic trap,
                       input logic redir, input logic [31:0] tgt);
    case (u)
      UALU: begin
        alu_valid_i = 1; alu_tag = tag; alu_rd = rd; alu_wb = wb;
        alu_result = res; alu_trap = trap;
      end
      UBR: begin
        branch_valid_i = 1; branch_tag = tag; branch_rd = rd; branch_wb = wb;
        branch_result = res; branch_trap = trap; branch_redirect = redir;
        branch_target = tgt;
      end
      UCS: begin
        ctrl_status_valid_i = 1; ctrl_status_tag = tag; ctrl_status_rd = rd;
        ctrl_status_wb = wb; ctrl_status_result = res; ctrl_status_trap = trap;
      end
      default: begin
        mem_valid_i = 1; mem_tag = tag; mem_rd = rd; mem_wb = wb;
        mem_result = res; mem_trap = trap;
      end
    endcase
  endtask

  task automatic clear_unit(input int u);
    case (u)
      UALU:    begin alu_valid_i = 0; alu_trap = 0; end
      UBR:     begin branch_valid_i = 0; branch_trap = 0; branch_redirect = 0; end
      UCS:     begin ctrl_status_valid_i = 0; ctrl_status_trap = 0; end
      default: begin mem_valid_i = 0; mem_trap = 0; end
    endcase
  endtask

  // Called at posedge+1: drives one record, expects it accepted this cycle,
  // records the expected write/redirect, returns at the next posedge+1.
  task automatic commit(input int u, input logic [3:0] tag, input logic [4:0] rd,
                        input logic wb, input logic [31:0] res, input logic trap,
                        input logic redir, input logic [31:0] tgt);
    drive(u, tag, rd, wb, res, trap, redir, tgt);
    @(negedge clk_core);
    chk($sformatf("ready_u%0d_tag%0d", u, tag), 64'(rdy(u)), 64'd1);
    chk("flush_req_run", 64'(flush_req), 64'd0);
    if (wb && !trap && rd != 5'd0) wq.push_back({rd, res});
    if (trap) rq.push_back(32'h0000_0100);
    else if (u == UBR && redir) rq.push_back(tgt);
    @(posedge clk_core); #1;
    clear_unit(u);
    hs_count++;
  endtask

  // Scoreboard monitors
  always @(negedge clk_core) begin
    if (rst_core_n) begin
      if (wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 64'(wr_en), 64'd0);
        else begin
          logic [36:0] e;
          e = wq.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e[36:32]));
          chk("wr_data", 64'(wr_data), 64'(e[31:0]));
        end
      end
      if (redirect_valid_o) begin
        if (rq.size() == 0) chk("redirect_unexpected", 64'(redirect_valid_o), 64'd0);
        else begin
          logic [31:0] p;
          p = rq.pop_front();
          chk("redirect_pc", 64'(redirect_pc_o), 64'(p));
        end
      end
    end
  end

  initial begin
    rst_core_n = 0; flush_ack = 0;
    clear_unit(UALU); clear_unit(UBR); clear_unit(UCS); clear_unit(UMEM);
    alu_tag = 0; alu_rd = 0; alu_wb = 0; alu_result = 0;
    branch_tag = 0; branch_rd = 0; branch_wb = 0; branch_result = 0; branch_target = 0;
    ctrl_status_tag = 0; ctrl_status_rd = 0; ctrl_status_wb = 0; ctrl_status_result = 0;
    mem_tag = 0; mem_rd = 0; mem_wb = 0; mem_result = 0;
    repeat (2) @(posedge clk_core);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_flush_req", 64'(flush_req), 64'd0);
    chk("rst_redirect_valid", 64'(redirect_valid_o), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc_o), 64'd0);
    chk("rst_retired", retired_count, 64'd0);
    chk("rst_ready", 64'({alu_ready_o, branch_ready_o, ctrl_status_ready_o, mem_ready_o}), 64'd0);
    rst_core_n = 1;
    @(posedge clk_core); #1;

    // In-order back-to-back commits
    commit(UALU, 0, 5, 1, 32'h11, 0, 0, 0);
    commit(UMEM, 1, 6, 1, 32'h22, 0, 0, 0);

    // Out-of-order arrival: mem tag3 waits for alu tag2
    drive(UMEM, 3, 9, 1, 32'h33, 0, 0, 0);
    @(negedge clk_core);
    chk("ooo_mem_wait", 64'(mem_ready_o), 64'd0);
    @(posedge clk_core); #1;
    drive(UALU, 2, 8, 1, 32'h44, 0, 0, 0);
    @(negedge clk_core);
    chk("ooo_alu_ready", 64'(alu_ready_o), 64'd1);
    chk("ooo_mem_still_wait", 64'(mem_ready_o), 64'd0);
    wq.push_back({5'd8, 32'h44});
    @(posedge clk_core); #1;
    clear_unit(UALU); hs_count++;
    @(negedge clk_core);
    chk("ooo_mem_ready", 64'(mem_ready_o), 64'd1);
    wq.push_back({5'd9, 32'h33});
    @(posedge clk_core); #1;
    clear_unit(UMEM); hs_count++;

    // Tag sweep up to and across the wrap
    for (int t = 4; t < 14; t++) commit(UALU, 4'(t), 5'(t + 10), 1, 32'(t * 3), 0, 0, 0);
    commit(UBR, 14, 2, 1, 32'hE, 0, 0, 0);
    commit(UCS, 15, 3, 1, 32'hF, 0, 0, 0);
    commit(UMEM, 0, 4, 1, 32'h100F, 0, 0, 0);
    commit(UALU, 1, 5, 1, 32'h1001, 0, 0, 0);

    // x0 write dropped
    commit(UALU, 2, 0, 1, 32'hDEAD, 0, 0, 0);
    @(negedge clk_core);
    chk("x0_no_wr", 64'(wr_en), 64'd0);
    @(posedge clk_core); #1;

    // Trap from ctrl_status: no write, redirect to trap vector, held flush
    commit(UCS, 3, 7, 1, 32'h77, 1, 0, 0);
    drive(UALU, 4, 9, 1, 32'h99, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_core);
      chk("trap_flush_req", 64'(flush_req), 64'd1);
      chk("trap_alu_blocked", 64'(alu_ready_o), 64'd0);
      chk("trap_redirect_pc_hold", 64'(redirect_pc_o), 64'h100);
      @(posedge clk_core); #1;
    end
    flush_ack = 1;
    @(negedge clk_core);
    chk("trap_ack_cycle_flush_req", 64'(flush_req), 64'd1);
    @(posedge clk_core); #1;
    flush_ack = 0;
    clear_unit(UALU);
    commit(UALU, 0, 8, 1, 32'h88, 0, 0, 0);

    // flush_ack in RUN is ignored
    flush_ack = 1;
    commit(UALU, 1, 3, 1, 32'h31, 0, 0, 0);
    flush_ack = 0;

    // Taken branch: link write plus redirect; alu blocked during flush
    commit(UBR, 2, 1, 1, 32'h1004, 0, 1, 32'h2000);
    drive(UALU, 3, 10, 1, 32'hAA, 0, 0, 0);
    @(negedge clk_core);
    chk("br_flush_req", 64'(flush_req), 64'd1);
    chk("br_alu_blocked", 64'(alu_ready_o), 64'd0);
    @(posedge clk_core); #1;
    @(negedge clk_core);
    chk("br_redirect_pulse_end", 64'(redirect_valid_o), 64'd0);
    chk("br_redirect_pc_hold", 64'(redirect_pc_o), 64'h2000);
    @(posedge clk_core); #1;
    flush_ack = 1;
    @(posedge clk_core); #1;
    flush_ack = 0;
    clear_unit(UALU);
    commit(UALU, 0, 11, 1, 32'hBB, 0, 0, 0);

    // Minimum-length flush: ack already high the cycle after the trap
    commit(UALU, 1, 12, 1, 32'hCC, 1, 0, 0);
    flush_ack = 1;
    @(negedge clk_core);
    chk("minflush_req", 64'(flush_req), 64'd1);
    @(posedge clk_core); #1;
    flush_ack = 0;
    commit(UALU, 0, 13, 1, 32'hDD, 0, 0, 0);

    // Retired counter (includes trap records)
`ifdef HSV_COMMIT_RETIRE_CNT_EN
    chk("retired_count", retired_count, 64'(hs_count));
`else
    chk("retired_count_off", retired_count, 64'd0);
`endif

    // Reset asserted mid-flush clears everything asynchronously
    commit(UCS, 1, 14, 1, 32'hEE, 1, 0, 0);
    @(negedge clk_core);
    chk("midflush_req", 64'(flush_req), 64'd1);
    #2;
    rst_core_n = 0;
    #1;
    chk("arst_flush_req", 64'(flush_req), 64'd0);
    chk("arst_redirect_pc", 64'(redirect_pc_o), 64'd0);
    chk("arst_wr_addr", 64'(wr_addr), 64'd0);
    chk("arst_retired", retired_count, 64'd0);
    @(posedge clk_core); #1;
    rst_core_n = 1;
    commit(UALU, 0, 4, 1, 32'h55, 0, 0, 0);

    repeat (3) @(posedge clk_core);
    #1;
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);
    chk("redirect_queue_drained", 64'(rq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
